// File: rtl/rd_data_checker_pkg.sv
// rtl/rd_data_checker_pkg.sv - shared constants, descriptor layout and LFSR step for the read-data checker
package rd_data_checker_pkg;

  localparam int AMM_DATA_W    = 128;
  localparam int AMM_BURST_W   = 11;
  localparam int ADDR_W        = 6;
  localparam int BYTE_PER_WORD = AMM_DATA_W / 8;
  localparam int BYTE_ADDR_W   = $clog2(BYTE_PER_WORD);
  localparam int DATA_B_W      = BYTE_PER_WORD;
  localparam int ADDR_B_W      = BYTE_ADDR_W;
  localparam int ERR_ADDR_W    = ADDR_W + ADDR_B_W;
  localparam int CNT_W         = BYTE_ADDR_W + 1;

  typedef enum logic {
    FIX_DATA = 1'b0,
    RND_DATA = 1'b1
  } ptrn_type_t;

  typedef struct packed {
    logic [ADDR_W-1:0]        word_address;
    logic [AMM_BURST_W-1:0]   burst_word_count;
    logic [BYTE_PER_WORD-1:0] start_mask;
    logic [BYTE_PER_WORD-1:0] end_mask;
    logic [7:0]               data_ptrn;
    ptrn_type_t               data_ptrn_type;
  } pkt_struct_t;

  localparam int PKT_W = $bits(pkt_struct_t);

  typedef enum logic {
    CHK_IDLE  = 1'b0,
    CHK_CHECK = 1'b1
  } chk_state_t;

  // Fibonacci form of x^8+x^6+x^5+x^4+1; must match the write-side generator bit for bit
  function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/rd_data_checker_exp_data_gen.sv
// rtl/rd_data_checker_exp_data_gen.sv - expected readdata word generator (fixed byte or LFSR stream)
module rd_data_checker_exp_data_gen
  import rd_data_checker_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic [7:0]            seed_i,
  input  logic                  advance_i,
  input  logic                  mode_i,
  input  logic [7:0]            ptrn_i,
  output logic [AMM_DATA_W-1:0] exp_data_o
);

  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_adv;

  // Lane i sees the state stepped i times; the state after the last lane is the next beat's seed
  always_comb begin
    logic [7:0] w_s;
    w_s        = r_lfsr;
    exp_data_o = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      exp_data_o[8*i +: 8] = mode_i ? w_s : ptrn_i;
      w_s = lfsr8_step(w_s);
    end
    w_lfsr_adv = w_s;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_lfsr <= '0;
    end else if (load_i) begin
      r_lfsr <= seed_i;
    end else if (advance_i) begin
      r_lfsr <= w_lfsr_adv;
    end
  end

endmodule

// File: rtl/rd_data_checker.sv
// rtl/rd_data_checker.sv - compares AMM readdata beats against a regenerated packet pattern
module rd_data_checker
  import rd_data_checker_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  pkt_valid_i,
  output logic                  pkt_ready_o,
  input  logic [PKT_W-1:0]      pkt_i,
  input  logic                  rdvalid_i,
  input  logic [AMM_DATA_W-1:0] rddata_i,
  input  logic                  err_clr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_flag_o,
  output logic [ERR_ADDR_W-1:0] err_addr_o,
  output logic [7:0]            err_data_o,
  output logic [31:0]           err_cnt_o,
  output logic                  stray_o
);

  chk_state_t r_state;
  chk_state_t w_state_nxt;

  pkt_struct_t w_pkt_in;
  pkt_struct_t r_pkt;

  logic [AMM_BURST_W-1:0] r_beat_cnt;
  logic [AMM_BURST_W-1:0] w_last;
  logic                   w_accept;
  logic                   w_beat;
  logic                   w_beat_last;

  logic [AMM_DATA_W-1:0]    w_exp;
  logic [BYTE_PER_WORD-1:0] w_mask;
  logic [BYTE_PER_WORD-1:0] w_miss;
  logic [CNT_W-1:0]         w_n;
  logic [ADDR_B_W-1:0]      w_lane;
  logic [7:0]               w_byte;
  logic [ADDR_W-1:0]        w_word_addr;

  logic        w_flag_base;
  logic [31:0] w_cnt_base;
  logic [32:0] w_sum;
  logic [31:0] w_cnt_sat;

  logic                  r_done;
  logic                  r_flag;
  logic [ERR_ADDR_W-1:0] r_addr;
  logic [7:0]            r_data;
  logic [31:0]           r_cnt;
  logic                  r_stray;

  assign w_pkt_in = pkt_i;

  // A zero word count still consumes one beat
  assign w_last      = (r_pkt.burst_word_count == '0) ? '0 : r_pkt.burst_word_count - 1'b1;
  assign w_beat_last = (r_beat_cnt == w_last);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= CHK_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    pkt_ready_o = 1'b0;
    busy_o      = 1'b0;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      CHK_IDLE: begin
        pkt_ready_o = 1'b1;
        w_accept    = pkt_valid_i;
        if (pkt_valid_i) begin
          w_state_nxt = CHK_CHECK;
        end
      end
      CHK_CHECK: begin
        busy_o = 1'b1;
        w_beat = rdvalid_i;
        if (rdvalid_i && w_beat_last) begin
          w_state_nxt = CHK_IDLE;
        end
      end
      default: w_state_nxt = CHK_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_pkt      <= '0;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_pkt      <= w_pkt_in;
      r_beat_cnt <= '0;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  // Seeded from the incoming descriptor so beat 0 is ready the cycle after acceptance
  rd_data_checker_exp_data_gen u_exp_data_gen (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (w_accept),
    .seed_i     (w_pkt_in.data_ptrn),
    .advance_i  (w_beat),
    .mode_i     (r_pkt.data_ptrn_type == RND_DATA),
    .ptrn_i     (r_pkt.data_ptrn),
    .exp_data_o (w_exp)
  );

  always_comb begin
    w_mask = '1;
    if (r_beat_cnt == '0) begin
      w_mask = w_mask & r_pkt.start_mask;
    end
    if (w_beat_last) begin
      w_mask = w_mask & r_pkt.end_mask;
    end
    w_miss = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      w_miss[i] = w_mask[i] & (rddata_i[8*i +: 8] != w_exp[8*i +: 8]);
    end
    w_n = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      w_n = w_n + CNT_W'(w_miss[i]);
    end
    // Scan from the top so the lowest failing lane is the one left standing
    w_lane = '0;
    w_byte = '0;
    for (int i = DATA_B_W - 1; i >= 0; i--) begin
      if (w_miss[i]) begin
        w_lane = ADDR_B_W'(i);
        w_byte = rddata_i[8*i +: 8];
      end
    end
  end

  assign w_word_addr = r_pkt.word_address + r_beat_cnt[ADDR_W-1:0];

  // A clear in the same cycle as a failing beat lets that beat become the new first error
  assign w_flag_base = r_flag & ~err_clr_i;
  assign w_cnt_base  = err_clr_i ? 32'd0 : r_cnt;
  assign w_sum       = {1'b0, w_cnt_base} + 33'(w_n);
  assign w_cnt_sat   = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_done  <= 1'b0;
      r_flag  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_stray <= 1'b0;
    end else begin
      r_done <= w_beat & w_beat_last;
      if (err_clr_i) begin
        r_flag  <= 1'b0;
        r_addr  <= '0;
        r_data  <= '0;
        r_cnt   <= '0;
        r_stray <= 1'b0;
      end
      if (w_beat && (w_n != '0)) begin
        r_cnt <= w_cnt_sat;
        if (!w_flag_base) begin
          r_flag <= 1'b1;
          r_addr <= {w_word_addr, w_lane};
          r_data <= w_byte;
        end
      end
      if ((r_state == CHK_IDLE) && rdvalid_i) begin
        r_stray <= 1'b1;
      end
    end
  end

  assign done_o     = r_done;
  assign err_flag_o = r_flag;
  assign err_addr_o = r_addr;
  assign err_data_o = r_data;
  assign err_cnt_o  = r_cnt;
  assign stray_o    = r_stray;

endmodule

// File: tb/tb_rd_data_checker.sv
// tb/tb_rd_data_checker.sv - directed and randomized self-checking bench for rd_data_checker
module tb_rd_data_checker;
  import rd_data_checker_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  pkt_valid;
  logic                  pkt_ready;
  pkt_struct_t           pkt;
  logic                  rdvalid;
  logic [AMM_DATA_W-1:0] rddata;
  logic                  err_clr;
  logic                  busy, done, err_flag, stray;
  logic [ERR_ADDR_W-1:0] err_addr;
  logic [7:0]            err_data;
  logic [31:0]           err_cnt;

  always #5 clk = ~clk;

  rd_data_checker dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .pkt_valid_i (pkt_valid),
    .pkt_ready_o (pkt_ready),
    .pkt_i       (pkt),
    .rdvalid_i   (rdvalid),
    .rddata_i    (rddata),
    .err_clr_i   (err_clr),
    .busy_o      (busy),
    .done_o      (done),
    .err_flag_o  (err_flag),
    .err_addr_o  (err_addr),
    .err_data_o  (err_data),
    .err_cnt_o   (err_cnt),
    .stray_o     (stray)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int n_done_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: whole packet expanded into a flat byte stream up front
  bit          m_busy, m_done, m_flag, m_stray;
  int          m_words, m_beat, m_waddr;
  logic [15:0] m_smask, m_emask;
  byte         m_exp[$];
  int          m_eaddr, m_edata;
  longint      m_cnt;

  function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
    return (s << 1) | 8'(^(s & 8'hB8));
  endfunction

  function automatic logic [AMM_DATA_W-1:0] good_word();
    logic [AMM_DATA_W-1:0] w = '0;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = m_exp[m_beat*16 + i];
    return w;
  endfunction

  task automatic model_step();
    m_done = 0;
    if (!rst_n) begin
      m_busy = 0; m_flag = 0; m_stray = 0; m_cnt = 0; m_eaddr = 0; m_edata = 0;
      return;
    end
    if (err_clr) begin
      m_flag = 0; m_stray = 0; m_cnt = 0; m_eaddr = 0; m_edata = 0;
    end
    if (!m_busy) begin
      if (rdvalid) m_stray = 1;
      if (pkt_valid) begin
        logic [7:0] s;
        m_busy  = 1;
        m_beat  = 0;
        m_words = (pkt.burst_word_count == 0) ? 1 : int'(pkt.burst_word_count);
        m_waddr = int'(pkt.word_address);
        m_smask = pkt.start_mask;
        m_emask = pkt.end_mask;
        m_exp.delete();
        s = pkt.data_ptrn;
        for (int k = 0; k < m_words*16; k++) begin
          m_exp.push_back((pkt.data_ptrn_type == RND_DATA) ? s : pkt.data_ptrn);
          s = ref_lfsr(s);
        end
      end
    end else if (rdvalid) begin
      int n = 0;
      int first = -1;
      logic [15:0] mask = 16'hFFFF;
      if (m_beat == 0) mask &= m_smask;
      if (m_beat == m_words - 1) mask &= m_emask;
      for (int i = 0; i < 16; i++) begin
        if (mask[i] && rddata[8*i +: 8] != m_exp[m_beat*16 + i]) begin
          n++;
          if (first < 0) first = i;
        end
      end
      if (n > 0) begin
        m_cnt = m_cnt + n;
        if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
        if (!m_flag) begin
          m_flag  = 1;
          m_eaddr = ((m_waddr + m_beat) % 64) * 16 + first;
          m_edata = int'(rddata[8*first +: 8]);
        end
      end
      if (m_beat == m_words - 1) begin
        m_busy = 0;
        m_done = 1;
      end
      m_beat++;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    if (done) n_done_seen++;
    chk("ready", pkt_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("err_flag", err_flag, m_flag);
    chk("err_addr", err_addr, m_eaddr[ERR_ADDR_W-1:0]);
    chk("err_data", err_data, m_edata[7:0]);
    chk("err_cnt", err_cnt, m_cnt[31:0]);
    chk("stray", stray, m_stray);
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; rdvalid = 0; err_clr = 0; rddata = '0;
  endtask

  task automatic send(input logic [5:0] a, input int cnt, input logic [15:0] sm, input logic [15:0] em,
                      input logic [7:0] ptrn, input bit rnd);
    pkt.word_address     = a;
    pkt.burst_word_count = AMM_BURST_W'(cnt);
    pkt.start_mask       = sm;
    pkt.end_mask         = em;
    pkt.data_ptrn        = ptrn;
    pkt.data_ptrn_type   = rnd ? RND_DATA : FIX_DATA;
    pkt_valid = 1;
    cycle();
    pkt_valid = 0;
  endtask

  // Sends the model's good word for the current beat with the lanes in flips XOR-corrupted
  task automatic beat(input logic [15:0] flips, input bit clr);
    rddata = good_word();
    for (int i = 0; i < 16; i++) if (flips[i]) rddata[8*i +: 8] ^= 8'h5A;
    rdvalid = 1; err_clr = clr;
    cycle();
    rdvalid = 0; err_clr = 0;
  endtask

  task automatic clear();
    err_clr = 1;
    cycle();
    err_clr = 0;
  endtask

  initial begin
    int d0;
    idle_inputs();
    pkt = '0;
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
    cycle();

    // Fixed pattern, clean data
    d0 = n_done_seen;
    send(6'h10, 4, 16'hFFFF, 16'hFFFF, 8'hA5, 0);
    for (int b = 0; b < 4; b++) beat(16'h0, 0);
    cycle();
    chk("fix_done_once", n_done_seen - d0, 1);
    chk("fix_cnt", err_cnt, 32'd0);

    // LFSR pattern, lane 3 of beat 1 corrupted
    send(6'h10, 2, 16'hFFFF, 16'hFFFF, 8'h01, 1);
    beat(16'h0, 0);
    beat(16'h0008, 0);
    chk("rnd_addr", err_addr, {6'h11, 4'h3});
    chk("rnd_cnt", err_cnt, 32'd1);
    clear();

    // Start/end masks across two beats, then a single fully-masked word
    send(6'h05, 2, 16'hFFF0, 16'h000F, 8'h3C, 0);
    beat(16'h0001, 0);
    beat(16'h8000, 0);
    chk("mask_clean", err_cnt, 32'd0);
    send(6'h05, 2, 16'hFFF0, 16'h000F, 8'h3C, 0);
    beat(16'h0010, 0);
    beat(16'h0000, 0);
    chk("mask_lane4", err_cnt, 32'd1);
    clear();
    send(6'h06, 1, 16'hFFF0, 16'h000F, 8'h77, 1);
    beat(16'h8011, 0);
    chk("mask_1word", err_cnt, 32'd0);

    // Word address wrap
    send(6'h3F, 2, 16'hFFFF, 16'hFFFF, 8'h9C, 1);
    beat(16'h0, 0);
    beat(16'h0001, 0);
    chk("wrap_addr", err_addr, {6'h00, 4'h0});
    clear();

    // Zero word count and stray beat
    d0 = n_done_seen;
    send(6'h02, 0, 16'hFFFF, 16'hFFFF, 8'h11, 0);
    beat(16'h0, 0);
    chk("zero_cnt_done", n_done_seen - d0, 1);
    rdvalid = 1; rddata = '1;
    cycle();
    rdvalid = 0;
    chk("stray_set", stray, 1'b1);
    chk("stray_cnt", err_cnt, 32'd0);
    clear();

    // Clear coincident with a failing beat
    send(6'h08, 2, 16'hFFFF, 16'hFFFF, 8'h00, 1);
    beat(16'h0100, 0);
    beat(16'h0204, 1);
    chk("clr_flag", err_flag, 1'b1);
    chk("clr_cnt", err_cnt, 32'd2);
    chk("clr_addr", err_addr, {6'h09, 4'h2});

    // Reset mid-packet, remaining beat becomes stray
    send(6'h20, 4, 16'hFFFF, 16'hFFFF, 8'h42, 0);
    beat(16'h0, 0);
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("rst_ready", pkt_ready, 1'b1);
    rdvalid = 1; rddata = '0;
    cycle();
    rdvalid = 0;
    chk("rst_stray", stray, 1'b1);
    clear();

    // Randomized packets against the model
    for (int p = 0; p < 60; p++) begin
      send(6'($urandom), $urandom_range(0, 4),
           ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF,
           ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF,
           8'($urandom), 1'($urandom));
      for (int g = 0; m_busy && g < 200; g++) begin
        if ($urandom_range(0, 3) != 0) begin
          rddata = good_word();
          if ($urandom_range(0, 3) == 0) rddata[8*$urandom_range(0, 15) +: 8] ^= 8'($urandom_range(1, 255));
          rdvalid = 1;
        end
        err_clr = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 7) == 0) begin
          pkt = pkt_struct_t'(PKT_W'({$urandom, $urandom}));
          pkt_valid = 1;
        end
        cycle();
        idle_inputs();
      end
      chk("rand_idle", m_busy, 1'b0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        rdvalid = ($urandom_range(0, 9) == 0);
        rddata  = {4{$urandom}};
        cycle();
        idle_inputs();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
